dot_matrix_scan_ctrl: RTL and testbench
=======================================

Name: dot_matrix_scan_ctrl

Overview:
Scan controller for the 16x16 dot-matrix display. It holds a 16-column frame buffer written by the host, one column per LOAD. It drives the display one column at a time: blank, latch the column data, then hold it for a fixed dwell. It sits between the host write interface and the column driver pins: column_seg, out_column, COLUMN_CLK and OUT_CLR.

Parameters:
DWELL, 1000, clock cycles each column is shown (OUT_CLR low); legal range >=1
BLANK, 4, clock cycles of blanking before each column latch; legal range >=1

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset
ENABLE  input  1  1 = scanning runs; 0 = display blanked, scan parked
LOAD  input  1  write strobe, one buffer write per cycle while high
column_id  input  5  write address; 0-15 valid, 16-31 ignored
in_column  input  16  column pixel data for the write; bit i = row i
IN_CLR  input  1  synchronous clear of the whole frame buffer
column_seg  output  4  index of the column being driven
out_column  output  16  row data for the driven column
COLUMN_CLK  output  1  one-cycle latch strobe to the column driver
OUT_CLR  output  1  1 = display blanked
frame_start  output  1  one-cycle pulse when the scan wraps to column 0

Behaviour:
- Clocking: single clock CLK, rising edge. RESET is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state = IDLE
  - column_seg = 0, out_column = 0
  - COLUMN_CLK = 0, OUT_CLR = 1, frame_start = 0
  - all 16 buffer words = 0
  - dwell/blank counter = 0
- Frame buffer (16 x 16 registers):
  - LOAD=1 and column_id[4]=0: buf[column_id[3:0]] <= in_column, visible from the next cycle.
  - LOAD=1 and column_id[4]=1: no write.
  - IN_CLR=1: all words <= 0. IN_CLR wins over LOAD in the same cycle, and that LOAD is dropped.
  - Writes never change out_column directly. New data appears only at the next LATCH of that column, so there is no tearing.
- FSM states: IDLE, BLANK, LATCH, SHOW.
  - IDLE:
    - OUT_CLR=1, out_column=0, column_seg=0.
    - ENABLE=1 -> BLANK, with the counter loaded to BLANK-1.
  - BLANK:
    - OUT_CLR=1, out_column=0.
    - Counter decrements each cycle. At 0 -> LATCH.
  - LATCH (exactly 1 cycle):
    - COLUMN_CLK=1, OUT_CLR=1.
    - out_column <= buf[column_seg], registered, valid on the same edge COLUMN_CLK rises.
    - -> SHOW, with the counter loaded to DWELL-1.
  - SHOW:
    - OUT_CLR=0, COLUMN_CLK=0, out_column held.
    - Counter at 0 -> BLANK. On that transition:
      - column_seg <= column_seg+1, wrapping 15 -> 0.
      - out_column <= 0.
      - frame_start=1 for that one cycle only when wrapping 15 -> 0.
- Column period = BLANK + 1 + DWELL cycles. Frame period = 16 x column period.
- COLUMN_CLK and OUT_CLR are never low together with a LATCH in progress. COLUMN_CLK only pulses while OUT_CLR=1.
- ENABLE=0 in any non-IDLE state: next cycle the FSM is in IDLE.
  - column_seg=0, out_column=0, OUT_CLR=1, COLUMN_CLK=0, frame_start=0.
  - Buffer contents are kept.
  - Re-enabling restarts at column 0 with a full BLANK.
- RESET low mid-scan: immediate return to reset values, including the buffer.
- Counter width is sized for max(DWELL, BLANK)-1 and never overflows.

Test Plan:
1. DWELL=8, BLANK=2; reset, then write buf[k]=16'h0001<<k for k=0..15; raise ENABLE.
   -> First COLUMN_CLK 3 cycles after ENABLE is sampled, with out_column=0001, column_seg=0.
   -> Subsequent COLUMN_CLK pulses every 11 cycles, with column_seg 1,2,...,15 and out_column = 1<<column_seg.
2. Run past column 15.
   -> frame_start pulses once, in the cycle column_seg returns to 0.
   -> Pulses are exactly 176 cycles apart.
   -> OUT_CLR low for exactly 8 cycles per column.
3. While column 5 is in SHOW, write buf[5]=16'hBEEF.
   -> out_column stays 0x0020 until that column ends.
   -> At the next frame's column-5 LATCH, out_column=BEEF.
4. LOAD with column_id=5'd20, data FFFF.
   -> No buffer change; full frame readback matches the prior contents.
   -> IN_CLR and LOAD(column_id=3, data=1234) in the same cycle: every column scans out 0000.
5. Drop ENABLE during SHOW of column 9.
   -> Next cycle: OUT_CLR=1, out_column=0, column_seg=0.
   -> On re-enable, the first latched column is 0 after 2 BLANK cycles, and buffer contents are intact.
6. Assert RESET low mid-LATCH.
   -> Outputs take reset values immediately, with no clock edge required.
   -> After release with ENABLE=1, all columns scan out 0000.

Source files
------------

// File: rtl/dot_matrix_scan_ctrl.sv
// Column-scan controller for a 16x16 dot-matrix display: host-written frame buffer,
// per-column blank / latch / dwell sequencing toward the column driver pins.
module dot_matrix_scan_ctrl #(
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        LOAD,
    input  logic [4:0]  column_id,
    input  logic [15:0] in_column,
    input  logic        IN_CLR,
    output logic [3:0]  column_seg,
    output logic [15:0] out_column,
    output logic        COLUMN_CLK,
    output logic        OUT_CLR,
    output logic        frame_start
);

    localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    logic [15:0]      frame_buf [16];
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Clear beats a same-cycle write; addresses 16-31 are silently dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 16; i++) frame_buf[i] <= '0;
        end else if (IN_CLR) begin
            for (int i = 0; i < 16; i++) frame_buf[i] <= '0;
        end else if (LOAD && !column_id[4]) begin
            frame_buf[column_id[3:0]] <= in_column;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            column_seg  <= '0;
            out_column  <= '0;
            COLUMN_CLK  <= 1'b0;
            OUT_CLR     <= 1'b1;
            frame_start <= 1'b0;
        end else if (!ENABLE) begin
            state       <= S_IDLE;
            cnt         <= '0;
            column_seg  <= '0;
            out_column  <= '0;
            COLUMN_CLK  <= 1'b0;
            OUT_CLR     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            COLUMN_CLK  <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    state      <= S_BLANK;
                    cnt        <= BLANK_LOAD;
                    column_seg <= '0;
                    out_column <= '0;
                    OUT_CLR    <= 1'b1;
                end
                S_BLANK: begin
                    if (cnt == '0) begin
                        // Data is sampled here so later writes never tear a shown column.
                        state      <= S_LATCH;
                        COLUMN_CLK <= 1'b1;
                        out_column <= frame_buf[column_seg];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    state   <= S_SHOW;
                    cnt     <= DWELL_LOAD;
                    OUT_CLR <= 1'b0;
                end
                default: begin
                    if (cnt == '0) begin
                        state       <= S_BLANK;
                        cnt         <= BLANK_LOAD;
                        OUT_CLR     <= 1'b1;
                        out_column  <= '0;
                        column_seg  <= column_seg + 4'd1;
                        frame_start <= (column_seg == 4'd15);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Directed bench for dot_matrix_scan_ctrl with DWELL=8, BLANK=2 (11-cycle column, 176-cycle frame).
module tb_dot_matrix_scan_ctrl;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int COL_P = BLANK + 1 + DWELL;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        LOAD;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        IN_CLR;
    logic [3:0]  column_seg;
    logic [15:0] out_column;
    logic        COLUMN_CLK;
    logic        OUT_CLR;
    logic        frame_start;

    int total;
    int bad;
    int cyc;
    int last_latch;

    dot_matrix_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .LOAD(LOAD),
        .column_id(column_id),
        .in_column(in_column),
        .IN_CLR(IN_CLR),
        .column_seg(column_seg),
        .out_column(out_column),
        .COLUMN_CLK(COLUMN_CLK),
        .OUT_CLR(OUT_CLR),
        .frame_start(frame_start)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic write_col(input logic [4:0] id, input logic [15:0] d);
        LOAD = 1'b1;
        column_id = id;
        in_column = d;
        @(negedge CLK);
        LOAD = 1'b0;
        column_id = '0;
        in_column = '0;
    endtask

    task automatic wait_latch_of(input logic [3:0] seg, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (COLUMN_CLK === 1'b1 && column_seg === seg) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        ENABLE = 1'b0;
        LOAD = 1'b0;
        IN_CLR = 1'b0;
        column_id = '0;
        in_column = '0;
        repeat (3) @(negedge CLK);
        total++; if (column_seg !== 4'd0) begin bad++; $display("FAIL reset_seg: got %0d want 0", column_seg); end
        total++; if (out_column !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", out_column); end
        total++; if (COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL reset_colclk: got %b want 0", COLUMN_CLK); end
        total++; if (OUT_CLR !== 1'b1) begin bad++; $display("FAIL reset_outclr: got %b want 1", OUT_CLR); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (OUT_CLR !== 1'b1 || COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL idle_parked: got clr=%b clk=%b want 1/0", OUT_CLR, COLUMN_CLK); end
    endtask

    task automatic test_first_scan;
        logic [15:0] exp;
        int lows;
        int pulses;
        for (int k = 0; k < 16; k++) write_col(5'(k), 16'h0001 << k);
        ENABLE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL first_blank1: colclk got %b want 0", COLUMN_CLK); end
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL first_blank2: colclk got %b want 0", COLUMN_CLK); end
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b1) begin bad++; $display("FAIL first_latch: colclk got %b want 1", COLUMN_CLK); end
        total++; if (out_column !== 16'h0001 || column_seg !== 4'd0) begin bad++; $display("FAIL first_latch_data: got seg=%0d out=%h want 0/0001", column_seg, out_column); end
        total++; if (OUT_CLR !== 1'b1) begin bad++; $display("FAIL first_latch_clr: got %b want 1", OUT_CLR); end
        for (int c = 1; c < 16; c++) begin
            lows = 0;
            pulses = 0;
            for (int i = 0; i < COL_P; i++) begin
                @(negedge CLK);
                if (OUT_CLR === 1'b0) lows++;
                if (COLUMN_CLK === 1'b1) pulses++;
            end
            exp = 16'h0001 << c;
            total++; if (COLUMN_CLK !== 1'b1 || column_seg !== 4'(c)) begin bad++; $display("FAIL col_latch: got clk=%b seg=%0d want 1/%0d", COLUMN_CLK, column_seg, c); end
            total++; if (out_column !== exp) begin bad++; $display("FAIL col_data: col %0d got %h want %h", c, out_column, exp); end
            total++; if (lows != DWELL || pulses != 1) begin bad++; $display("FAIL col_timing: col %0d got lows=%0d pulses=%0d want %0d/1", c, lows, pulses, DWELL); end
        end
        last_latch = cyc;
    endtask

    task automatic test_frame_wrap;
        int pulses;
        int first;
        int second;
        pulses = 0;
        first = 0;
        second = 0;
        for (int i = 0; i < 400 && pulses < 2; i++) begin
            @(negedge CLK);
            if (frame_start === 1'b1) begin
                if (pulses == 0) first = cyc; else second = cyc;
                pulses++;
                total++; if (column_seg !== 4'd0) begin bad++; $display("FAIL fs_seg: got %0d want 0", column_seg); end
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL fs_count: got %0d want 2", pulses); end
        total++; if (first - last_latch != DWELL + 1) begin bad++; $display("FAIL fs_first: got %0d want %0d", first - last_latch, DWELL + 1); end
        total++; if (second - first != 16 * COL_P) begin bad++; $display("FAIL fs_period: got %0d want %0d", second - first, 16 * COL_P); end
    endtask

    task automatic test_no_tearing;
        bit ok;
        int lows;
        wait_latch_of(4'd5, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL tear_wait: got timeout want latch of col 5"); end
        total++; if (out_column !== 16'h0020) begin bad++; $display("FAIL tear_pre: got %h want 0020", out_column); end
        @(negedge CLK);
        write_col(5'd5, 16'hBEEF);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (OUT_CLR !== 1'b0) break;
            lows++;
            total++; if (out_column !== 16'h0020) begin bad++; $display("FAIL tear_hold: got %h want 0020", out_column); end
            @(negedge CLK);
        end
        total++; if (lows != DWELL - 1) begin bad++; $display("FAIL tear_len: got %0d want %0d", lows, DWELL - 1); end
        total++; if (out_column !== 16'h0000 || column_seg !== 4'd6) begin bad++; $display("FAIL tear_end: got out=%h seg=%0d want 0000/6", out_column, column_seg); end
        wait_latch_of(4'd5, 200, ok);
        total++; if (!ok || out_column !== 16'hBEEF) begin bad++; $display("FAIL tear_new: got ok=%b out=%h want 1/beef", ok, out_column); end
    endtask

    task automatic test_ignored_addr;
        bit ok;
        logic [15:0] exp [16];
        for (int k = 0; k < 16; k++) exp[k] = 16'h0001 << k;
        exp[5] = 16'hBEEF;
        write_col(5'd20, 16'hFFFF);
        for (int c = 0; c < 16; c++) begin
            wait_latch_of(4'(c), 200, ok);
            total++; if (!ok || out_column !== exp[c]) begin bad++; $display("FAIL ignore_rb: col %0d got ok=%b out=%h want %h", c, ok, out_column, exp[c]); end
        end
        IN_CLR = 1'b1;
        LOAD = 1'b1;
        column_id = 5'd3;
        in_column = 16'h1234;
        @(negedge CLK);
        IN_CLR = 1'b0;
        LOAD = 1'b0;
        column_id = '0;
        in_column = '0;
        for (int c = 0; c < 16; c++) begin
            wait_latch_of(4'(c), 200, ok);
            total++; if (!ok || out_column !== 16'h0000) begin bad++; $display("FAIL clear_rb: col %0d got ok=%b out=%h want 0000", c, ok, out_column); end
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        for (int k = 0; k < 16; k++) write_col(5'(k), 16'hA000 | 16'(k));
        wait_latch_of(4'd9, 200, ok);
        total++; if (!ok || out_column !== 16'hA009) begin bad++; $display("FAIL en_pre: got ok=%b out=%h want a009", ok, out_column); end
        @(negedge CLK);
        total++; if (OUT_CLR !== 1'b0 || column_seg !== 4'd9) begin bad++; $display("FAIL en_show: got clr=%b seg=%0d want 0/9", OUT_CLR, column_seg); end
        ENABLE = 1'b0;
        @(negedge CLK);
        total++; if (OUT_CLR !== 1'b1 || COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL en_off_ctl: got clr=%b clk=%b want 1/0", OUT_CLR, COLUMN_CLK); end
        total++; if (out_column !== 16'h0000 || column_seg !== 4'd0) begin bad++; $display("FAIL en_off_data: got out=%h seg=%0d want 0000/0", out_column, column_seg); end
        repeat (3) @(negedge CLK);
        total++; if (OUT_CLR !== 1'b1 || COLUMN_CLK !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL en_parked: got clr=%b clk=%b fs=%b want 1/0/0", OUT_CLR, COLUMN_CLK, frame_start); end
        ENABLE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL reen_blank1: got %b want 0", COLUMN_CLK); end
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b0) begin bad++; $display("FAIL reen_blank2: got %b want 0", COLUMN_CLK); end
        @(negedge CLK);
        total++; if (COLUMN_CLK !== 1'b1 || column_seg !== 4'd0 || out_column !== 16'hA000) begin bad++; $display("FAIL reen_latch: got clk=%b seg=%0d out=%h want 1/0/a000", COLUMN_CLK, column_seg, out_column); end
        wait_latch_of(4'd9, 200, ok);
        total++; if (!ok || out_column !== 16'hA009) begin bad++; $display("FAIL reen_intact: got ok=%b out=%h want a009", ok, out_column); end
    endtask

    task automatic test_reset_mid_latch;
        bit ok;
        wait_latch_of(4'd3, 200, ok);
        total++; if (!ok || out_column !== 16'hA003) begin bad++; $display("FAIL rst_pre: got ok=%b out=%h want a003", ok, out_column); end
        #1 RESET = 1'b0;
        #1;
        total++; if (COLUMN_CLK !== 1'b0 || OUT_CLR !== 1'b1) begin bad++; $display("FAIL rst_async_ctl: got clk=%b clr=%b want 0/1", COLUMN_CLK, OUT_CLR); end
        total++; if (out_column !== 16'h0000 || column_seg !== 4'd0 || frame_start !== 1'b0) begin bad++; $display("FAIL rst_async_data: got out=%h seg=%0d fs=%b want 0000/0/0", out_column, column_seg, frame_start); end
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c < 16; c++) begin
            wait_latch_of(4'(c), 200, ok);
            total++; if (!ok || out_column !== 16'h0000) begin bad++; $display("FAIL rst_rb: col %0d got ok=%b out=%h want 0000", c, ok, out_column); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_first_scan();
        test_frame_wrap();
        test_no_tearing();
        test_ignored_addr();
        test_enable_drop();
        test_reset_mid_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
